// File: rtl/sha3_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sha3_fifo_pkg
//  Description : Shared types and default sizing for the SHA3 lane FIFOs.
//                lane_t         - one 64-bit Keccak lane
//                FIFO_DATA_SIZE - default word width (64)
//                FIFO_ADDR_SPACE- default address bits (4 -> 16 entries)
//                fifo_status_t  - bundled status view for FIFO consumers
//  Revision    : 1.0  initial release
// ============================================================================
package sha3_fifo_pkg;

  typedef logic [63:0] lane_t;

  localparam int FIFO_DATA_SIZE  = 64;
  localparam int FIFO_ADDR_SPACE = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage : sha3_fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port storage array for sync_fifo_flex.
//                Synchronous write, asynchronous (combinational) read.
//                Contents are intentionally not reset.
//  Ports       : clk        - write clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write address
//                wr_data_i  - write word
//                rd_addr_i  - read address
//                rd_data_o  - word at rd_addr_i
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_SPACE = 4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_SPACE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0]  wr_data_i,
  input  logic [ADDR_SPACE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0]  rd_data_o
);

  localparam int C_DEPTH = 2**ADDR_SPACE;

  logic [DATA_SIZE-1:0] mem_q [0:C_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flex
//  Description : Single-clock FIFO with programmable almost-full/almost-empty
//                thresholds, occupancy count, synchronous flush, sticky
//                overflow/underflow flags and a registered rd_valid.
//  Config macro: SYNC_FIFO_FWFT_EN
//                  defined   - first-word-fall-through: rd_data shows the head
//                              word combinationally, rd_valid = ~empty
//                  undefined - registered read, 1-cycle latency, rd_valid
//                              pulses for one cycle per accepted read
//  Ports       : clk, rst (async, active high)
//                flush            - synchronous clear of pointers/flags
//                wr_en, wr_data   - write request and word
//                rd_en            - read request (pop)
//                rd_data, rd_valid- read word and its qualifier
//                empty, full, almost_full, almost_empty, count - status
//                overflow, underflow - sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_flex
  import sha3_fifo_pkg::*;
#(
  parameter int DATA_SIZE  = FIFO_DATA_SIZE,
  parameter int ADDR_SPACE = FIFO_ADDR_SPACE,
  parameter int AFULL_TH   = (2**ADDR_SPACE) - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_SIZE-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_SIZE-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SPACE:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                C_DEPTH     = 2**ADDR_SPACE;
  localparam logic [ADDR_SPACE:0] C_DEPTH_CNT = {1'b1, {ADDR_SPACE{1'b0}}};
  localparam logic [ADDR_SPACE:0] C_ONE       = {{ADDR_SPACE{1'b0}}, 1'b1};
  localparam logic [ADDR_SPACE:0] C_AFULL     = (ADDR_SPACE+1)'(AFULL_TH);
  localparam logic [ADDR_SPACE:0] C_AEMPTY    = (ADDR_SPACE+1)'(AEMPTY_TH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (DATA_SIZE < 1) begin : g_bad_data_size
    $fatal(1, "sync_fifo_flex: DATA_SIZE must be >= 1");
  end
  if (ADDR_SPACE < 1) begin : g_bad_addr_space
    $fatal(1, "sync_fifo_flex: ADDR_SPACE must be >= 1");
  end
  if (AFULL_TH < 1 || AFULL_TH > C_DEPTH) begin : g_bad_afull_th
    $fatal(1, "sync_fifo_flex: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > C_DEPTH - 1) begin : g_bad_aempty_th
    $fatal(1, "sync_fifo_flex: AEMPTY_TH out of range 0..DEPTH-1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Pointers carry one extra bit so they wrap modulo 2*DEPTH; only the low
  // bits address memory. Occupancy is kept in its own register so that every
  // status flag is a plain decode of a flop.
  logic [ADDR_SPACE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SPACE:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SPACE:0] count_q,  count_d;
  logic                overflow_q,  overflow_d;
  logic                underflow_q, underflow_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic [DATA_SIZE-1:0] mem_rd_data;

  assign empty        = (count_q == '0);
  assign full         = (count_q == C_DEPTH_CNT);
  assign almost_full  = (count_q >= C_AFULL);
  assign almost_empty = (count_q <= C_AEMPTY);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush masks both requests so a flush cycle neither moves data nor
  // raises an error flag.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + C_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + C_ONE;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
      // A write while full is dropped even if a read pops in the same cycle.
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  fifo_mem #(
    .DATA_SIZE  (DATA_SIZE),
    .ADDR_SPACE (ADDR_SPACE)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_SPACE-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[ADDR_SPACE-1:0]),
    .rd_data_o (mem_rd_data)
  );

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible without a request; forced to zero while empty so
  // stale memory never leaks out and the reset value of rd_data is 0.
  assign rd_data  = empty ? '0 : mem_rd_data;
  assign rd_valid = ~empty;
`else
  logic [DATA_SIZE-1:0] rd_data_q,  rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_data_d = mem_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule : sync_fifo_flex
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_flex
//  Description : Directed self-checking bench for sync_fifo_flex with a
//                queue scoreboard; honours SYNC_FIFO_FWFT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_flex;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo_flex #(
    .DATA_SIZE  (DW),
    .ADDR_SPACE (AW),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic        ovf_m = 1'b0;
  logic        unf_m = 1'b0;
  logic [63:0] last_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"},  64'(count),        64'(sb.size()));
    chk({tag, ".empty"},  64'(empty),        64'(sb.size() == 0));
    chk({tag, ".full"},   64'(full),         64'(sb.size() == DEPTH));
    chk({tag, ".afull"},  64'(almost_full),  64'(sb.size() >= 14));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(sb.size() <= 2));
    chk({tag, ".ovf"},    64'(overflow),     64'(ovf_m));
    chk({tag, ".unf"},    64'(underflow),    64'(unf_m));
  endtask

  // One clock of stimulus; the scoreboard is updated from pre-edge state.
  task automatic cycle(input string tag, input logic wr, input logic [63:0] d,
                       input logic rd, input logic fl);
    logic rd_acc_m;
    logic full_m;
    logic empty_m;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    flush   = fl;
    full_m   = (sb.size() == DEPTH);
    empty_m  = (sb.size() == 0);
    rd_acc_m = 1'b0;
    if (fl) begin
      sb.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (wr && full_m)  ovf_m = 1'b1;
      if (rd && empty_m) unf_m = 1'b1;
      if (rd && !empty_m) begin
        rd_acc_m = 1'b1;
        last_m   = sb.pop_front();
      end
      if (wr && !full_m) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    chk_status(tag);
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(sb.size() != 0));
    chk({tag, ".rd_data"},  rd_data, (sb.size() != 0) ? sb[0] : 64'h0);
`else
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(rd_acc_m));
    chk({tag, ".rd_data"},  rd_data, last_m);
`endif
  endtask

  // Asserts rst from wherever we are; outputs must go to reset values at once.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    sb.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    last_m = '0;
    chk_status(tag);
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'h0);
    chk({tag, ".rd_data"},  rd_data,       64'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #2;
    do_reset("reset");

    // Single word round trip
    cycle("s1_wr", 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);
    cycle("s1_rd", 1'b0, 64'h0, 1'b1, 1'b0);
    cycle("s1_idle", 1'b0, 64'h0, 1'b0, 1'b0);

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) cycle("s2_fill", 1'b1, 64'(i), 1'b0, 1'b0);
    cycle("s2_ovf", 1'b1, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("s2_drain", 1'b0, 64'h0, 1'b1, 1'b0);

    // Sustained simultaneous read/write at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) cycle("s3_fill", 1'b1, 64'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("s3_rw", 1'b1, 64'(200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle("s3_drain", 1'b0, 64'h0, 1'b1, 1'b0);

    // Read while empty with a simultaneous write
    cycle("s4_unf", 1'b1, 64'h1234567890ABCDEF, 1'b1, 1'b0);
    cycle("s4_rd", 1'b0, 64'h0, 1'b1, 1'b0);

    // Flush at count 5 with overflow still set, write ignored
    for (int i = 0; i < 5; i++) cycle("s5_fill", 1'b1, 64'(300 + i), 1'b0, 1'b0);
    cycle("s5_flush", 1'b1, 64'hFFFF0000FFFF0000, 1'b1, 1'b1);
    cycle("s5_wr", 1'b1, 64'h0BADF00D0BADF00D, 1'b0, 1'b0);
    cycle("s5_rd", 1'b0, 64'h0, 1'b1, 1'b0);
    cycle("s5_idle", 1'b0, 64'h0, 1'b0, 1'b0);

    // Reset mid-burst at count 7, then repeat the round trip
    for (int i = 0; i < 7; i++) cycle("s6_fill", 1'b1, 64'(400 + i), 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 64'h7777777777777777;
    do_reset("s6_rst");
    cycle("s6_wr", 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);
    cycle("s6_hold", 1'b0, 64'h0, 1'b0, 1'b0);
    cycle("s6_rd", 1'b0, 64'h0, 1'b1, 1'b0);
    cycle("s6_idle", 1'b0, 64'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_sync_fifo_flex
`default_nettype wire

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the successor to the plain synchronous FIFO used between the SHA3 input interface and the Keccak absorb datapath. It adds programmable almost-full/almost-empty thresholds, an occupancy count, synchronous flush, sticky overflow/underflow error flags and a registered `rd_valid`. A compile-time first-word-fall-through read mode is also available. It buffers 64-bit lanes by default and is reused for the squeeze-side output queue.

## Interface
- `DATA_SIZE`, 64: word width in bits.
- `ADDR_SPACE`, 4: address bits; DEPTH = 2**ADDR_SPACE (16).
- `AFULL_TH`, DEPTH-2: `almost_full` asserts when count >= AFULL_TH; legal range 1..DEPTH.
- `AEMPTY_TH`, 2: `almost_empty` asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of contents and error flags.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_SIZE  write word.
- `rd_en`  in  1  read request (pop).
- `rd_data`  out  DATA_SIZE  read word.
- `rd_valid`  out  1  `rd_data` holds a popped or head word.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count >= AFULL_TH.
- `almost_empty`  out  1  count <= AEMPTY_TH.
- `count`  out  ADDR_SPACE+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a write was attempted while full.
- `underflow`  out  1  sticky; a read was attempted while empty.

## Operation
- Pointers are ADDR_SPACE+1 bits wide. The low bits index memory; the pointers wrap naturally modulo 2·DEPTH. The count register is updated alongside the pointers.
- Write acceptance: `wr_acc = wr_en & ~full`. Read acceptance: `rd_acc = rd_en & ~empty`. Flags are evaluated on the pre-edge count.
- Both requests accepted in the same cycle: both pointers advance and count is unchanged.
- `wr_en` while full: the word is dropped, memory and pointers are unchanged, and `overflow` is set. This holds even if `rd_en` is also high in that cycle.
- `rd_en` while empty: no pop occurs and `underflow` is set. A simultaneous write is still accepted.
- `flush` has the highest priority below `rst`. On a flush cycle:
  - pointers and count go to 0;
  - `overflow`, `underflow` and `rd_valid` clear;
  - `wr_en` and `rd_en` are ignored and flag nothing;
  - memory contents are not cleared.
- Status flags are pure decodes of the count register, so they are glitch-free and change on the edge after the causing request.
- `rst` takes effect mid-operation from any state, with no handshake.
- Reset values:
  - count 0, empty 1, full 0;
  - almost_full 0, almost_empty 1;
  - overflow 0, underflow 0;
  - rd_valid 0, rd_data 0.
- Out-of-range parameters stop elaboration via `$fatal`.

## Timing
- Write to visible: a word written at edge N raises count and clears `empty` after edge N.
- Standard mode: `rd_data` is registered. An accepted read at edge N presents the data after edge N, with `rd_valid` high for exactly that one cycle. `rd_data` holds its value when no read is accepted.
- FWFT mode: read latency is 0. `rd_data` shows the head word whenever `empty` is 0, `rd_valid = ~empty`, and `rd_en` pops the word on the edge.
- Sustained throughput is one write plus one read per cycle at any occupancy from 1 to DEPTH-1.
- Wrap-around needs no bubble: pointer DEPTH-1 is followed by 0 on the next access.

## Configuration
- `SYNC_FIFO_FWFT_EN`:
  - Defined: first-word-fall-through mode. The head word is read combinationally from memory and `rd_valid` mirrors `~empty`.
  - Undefined: standard registered-read mode, with 1-cycle latency and a pulsed `rd_valid`.
- All other behaviour is identical in both modes.

## Structure
- `sha3_fifo_pkg` holds:
  - `lane_t` (logic [63:0]);
  - default constants `FIFO_DATA_SIZE` = 64 and `FIFO_ADDR_SPACE` = 4;
  - a `fifo_status_t` packed struct {empty, full, almost_full, almost_empty, overflow, underflow} for consumers.
- Sub-module `fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parametrised by DATA_SIZE and ADDR_SPACE. The read register for standard mode lives in `sync_fifo_flex`.

## Test plan
- Reset, then write 0xA5A5A5A5A5A5A5A5 and read it. Required: in standard mode, data appears the cycle after `rd_en` with a 1-cycle `rd_valid` pulse; `empty` returns to 1 and count to 0.
- Write 16 words 0..15. Required: `almost_full` rises at count 14 and `full` at 16. A 17th write of 0xDEADBEEFDEADBEEF sets `overflow`, and reads then return 0..15 in order.
- At count 8, assert write and read together for 20 cycles with an incrementing pattern. Required: count stays 8, no flag toggles, pointers wrap, and the read order is intact.
- Read while empty together with a write of 0x1234567890ABCDEF. Required: `underflow` = 1, count = 1, and the next read returns 0x1234567890ABCDEF.
- At count 5 with `overflow` set, pulse `flush` together with `wr_en`. Required: next cycle count 0, `empty` 1, `overflow` 0, and no word written.
- Assert `rst` mid-burst at count 7, then re-run the first scenario with `SYNC_FIFO_FWFT_EN` defined. Required: all outputs take their reset values immediately, and in FWFT mode `rd_data` equals the head word with no `rd_en`.
